// File: rtl/button_adder_display.sv
// Button-driven adder: debounces the enter button, captures two operands,
// registers their sum/carry and drives a multiplexed hex 7-segment display.
module button_adder_display #(
    parameter int W            = 4,
    parameter int DEBOUNCE_CYC = 4,
    parameter int N_DIG        = 2,
    parameter int REFRESH_CYC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     btn_input,
    input  logic             btn_enter,
    output logic [W-1:0]     f_out,
    output logic             L_out,
    output logic [6:0]       seg7_out,
    output logic [N_DIG-1:0] an_out,
    output logic [1:0]       state_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam int REF_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int DV_W  = 4 * N_DIG;
    localparam int EXT_W = (DV_W > W + 1) ? DV_W : W + 1;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     f_q;
    logic             l_q;
    logic [W:0]       sum_d;

    logic [REF_W-1:0] ref_q;
    logic [IDX_W-1:0] idx_q;
    logic [EXT_W-1:0] dv_ext;
    logic [DV_W-1:0]  dv;
    logic [3:0]       nibble;

    // The pulse is issued on the same edge that flips db high, so the FSM
    // reacts one edge later without an extra edge-detect register.
    always_comb begin
        cnt_d   = cnt_q;
        db_d    = db_q;
        pulse_d = 1'b0;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            cnt_d   = '0;
            db_d    = sync2_q;
            pulse_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_enter;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign sum_d = {1'b0, a_q} + {1'b0, btn_input};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            f_q     <= '0;
            l_q     <= 1'b0;
        end else if (pulse_q) begin
            case (state_q)
                WAIT_A: begin
                    a_q     <= btn_input;
                    state_q <= WAIT_B;
                end
                WAIT_B: begin
                    f_q     <= sum_d[W-1:0];
                    l_q     <= sum_d[W];
                    state_q <= SHOW;
                end
                SHOW: begin
                    a_q     <= btn_input;
                    state_q <= WAIT_B;
                end
                default: begin
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_q <= '0;
            idx_q <= '0;
        end else if (ref_q == REF_W'(REFRESH_CYC - 1)) begin
            ref_q <= '0;
            idx_q <= (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            ref_q <= ref_q + REF_W'(1);
        end
    end

    always_comb begin
        case (state_q)
            WAIT_B:  dv_ext = EXT_W'(a_q);
            SHOW:    dv_ext = EXT_W'({l_q, f_q});
            default: dv_ext = '0;
        endcase
        dv = dv_ext[DV_W-1:0];
    end

    always_comb begin
        nibble = 4'h0;
        an_out = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble    = dv[4*i +: 4];
                an_out[i] = 1'b1;
            end
        end
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign seg7_out  = hex_to_seg(nibble);
    assign f_out     = f_q;
    assign L_out     = l_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_button_adder_display.sv
// Randomised and directed bench for button_adder_display, checked against a
// press-level model of the adder and display contents.
module tb_button_adder_display;

    localparam int W  = 4;
    localparam int DC = 4;
    localparam int ND = 2;
    localparam int RC = 8;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  btn_input = '0;
    logic          btn_enter = 1'b0;
    logic [W-1:0]  f_out;
    logic          L_out;
    logic [6:0]    seg7_out;
    logic [ND-1:0] an_out;
    logic [1:0]    state_out;

    int nCompared = 0;
    int nMismatched = 0;

    // Press-level model: state 0/1/2, operand a, and (W+1)-bit sum
    int mState = 0;
    int mA = 0;
    int mSum = 0;

    button_adder_display #(
        .W(W), .DEBOUNCE_CYC(DC), .N_DIG(ND), .REFRESH_CYC(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_input(btn_input), .btn_enter(btn_enter),
        .f_out(f_out), .L_out(L_out), .seg7_out(seg7_out), .an_out(an_out),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void modelPress(input int val);
        case (mState)
            0: begin mA = val; mState = 1; end
            1: begin mSum = mA + val; mState = 2; end
            default: begin mA = val; mState = 1; end
        endcase
    endfunction

    function automatic logic [6:0] expSeg(input int d);
        int dv;
        dv = (mState == 0) ? 0 : (mState == 1) ? mA : mSum;
        return HEX_TAB[(dv >> (4 * d)) & 15];
    endfunction

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        btn_enter = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mState = 0;
        mA = 0;
        mSum = 0;
    endtask

    // Press held 10 cycles, released 10 cycles; optionally scramble the
    // switches after the capture edge to show they no longer matter.
    task automatic applyStimulus(input int val, input bit scramble);
        @(negedge clk);
        btn_input = W'(val);
        btn_enter = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        if (scramble) btn_input = W'($urandom_range(0, 15));
        repeat (2) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        modelPress(val);
    endtask

    task automatic waitDigit(input int d, output logic [6:0] seg, output bit timedOut);
        timedOut = 1'b1;
        seg = '0;
        for (int i = 0; i < 4 * RC * ND; i++) begin
            if (an_out == ND'(1 << d)) begin
                seg = seg7_out;
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        doReset(3);
        nCompared++;
        if (state_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_state: got %b expected 00", state_out); end
        nCompared++;
        if (f_out !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_f: got %h expected 0", f_out); end
        nCompared++;
        if (L_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_L: got %b expected 0", L_out); end
        nCompared++;
        if (an_out !== 2'b01) begin nMismatched++; $display("[TB] FAIL reset_an: got %b expected 01", an_out); end
        nCompared++;
        if (seg7_out !== 7'h3F) begin nMismatched++; $display("[TB] FAIL reset_seg: got %h expected 3F", seg7_out); end
        repeat (7) @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (an_out !== 2'b01) begin nMismatched++; $display("[TB] FAIL refresh_hold: got %b expected 01", an_out); end
        @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (an_out !== 2'b10) begin nMismatched++; $display("[TB] FAIL refresh_wrap: got %b expected 10", an_out); end
        nCompared++;
        if (seg7_out !== 7'h3F) begin nMismatched++; $display("[TB] FAIL reset_seg_d1: got %h expected 3F", seg7_out); end
    endtask

    task automatic test_basic_add;
        logic [6:0] seg;
        bit to;
        applyStimulus(3, 1'b0);
        nCompared++;
        if (state_out !== 2'b01) begin nMismatched++; $display("[TB] FAIL add_stateB: got %b expected 01", state_out); end
        waitDigit(0, seg, to);
        nCompared++;
        if (to || seg !== 7'h4F) begin nMismatched++; $display("[TB] FAIL add_showA: got %h (timeout %0d) expected 4F", seg, to); end
        applyStimulus(5, 1'b0);
        nCompared++;
        if (f_out !== 4'h8) begin nMismatched++; $display("[TB] FAIL add_f: got %h expected 8", f_out); end
        nCompared++;
        if (L_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_L: got %b expected 0", L_out); end
        nCompared++;
        if (state_out !== 2'b10) begin nMismatched++; $display("[TB] FAIL add_stateS: got %b expected 10", state_out); end
        waitDigit(0, seg, to);
        nCompared++;
        if (to || seg !== 7'h7F) begin nMismatched++; $display("[TB] FAIL add_d0: got %h (timeout %0d) expected 7F", seg, to); end
        waitDigit(1, seg, to);
        nCompared++;
        if (to || seg !== 7'h3F) begin nMismatched++; $display("[TB] FAIL add_d1: got %h (timeout %0d) expected 3F", seg, to); end
    endtask

    task automatic test_carry;
        logic [6:0] seg;
        bit to;
        applyStimulus(9, 1'b0);
        applyStimulus(10, 1'b0);
        nCompared++;
        if (f_out !== 4'h3) begin nMismatched++; $display("[TB] FAIL carry_f: got %h expected 3", f_out); end
        nCompared++;
        if (L_out !== 1'b1) begin nMismatched++; $display("[TB] FAIL carry_L: got %b expected 1", L_out); end
        waitDigit(0, seg, to);
        nCompared++;
        if (to || seg !== 7'h4F) begin nMismatched++; $display("[TB] FAIL carry_d0: got %h (timeout %0d) expected 4F", seg, to); end
        waitDigit(1, seg, to);
        nCompared++;
        if (to || seg !== 7'h06) begin nMismatched++; $display("[TB] FAIL carry_d1: got %h (timeout %0d) expected 06", seg, to); end
        applyStimulus(2, 1'b0);
        nCompared++;
        if (state_out !== 2'b01) begin nMismatched++; $display("[TB] FAIL restart_state: got %b expected 01", state_out); end
        nCompared++;
        if (f_out !== 4'h3) begin nMismatched++; $display("[TB] FAIL restart_fhold: got %h expected 3", f_out); end
    endtask

    task automatic test_glitch_latency;
        logic [6:0] seg;
        bit to;
        bit early;
        int transitions;
        logic [1:0] prev;
        doReset(2);
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (state_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL glitch_ignored: got %b expected 00", state_out); end

        btn_input = 4'hC;
        btn_enter = 1'b1;
        early = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (state_out !== 2'b00) early = 1'b1;
        end
        nCompared++;
        if (early) begin nMismatched++; $display("[TB] FAIL latency_early: got 1 expected 0"); end
        @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (state_out !== 2'b01) begin nMismatched++; $display("[TB] FAIL latency_edge: got %b expected 01", state_out); end
        modelPress(12);

        transitions = 1;
        prev = state_out;
        for (int j = 0; j < 43; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (state_out !== prev) transitions++;
            prev = state_out;
        end
        btn_enter = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (state_out !== prev) transitions++;
            prev = state_out;
        end
        nCompared++;
        if (transitions != 1) begin nMismatched++; $display("[TB] FAIL hold_one_pulse: got %0d expected 1", transitions); end
        waitDigit(0, seg, to);
        nCompared++;
        if (to || seg !== 7'h39) begin nMismatched++; $display("[TB] FAIL hold_showA: got %h (timeout %0d) expected 39", seg, to); end
    endtask

    task automatic test_capture_timing;
        logic [6:0] seg;
        bit to;
        doReset(1);
        @(negedge clk);
        btn_input = 4'h6;
        btn_enter = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_input = 4'h7;
        repeat (7) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        modelPress(7);
        nCompared++;
        if (state_out !== 2'b01) begin nMismatched++; $display("[TB] FAIL capture_state: got %b expected 01", state_out); end
        waitDigit(0, seg, to);
        nCompared++;
        if (to || seg !== 7'h07) begin nMismatched++; $display("[TB] FAIL capture_value: got %h (timeout %0d) expected 07", seg, to); end
    endtask

    task automatic test_reset_midop;
        logic [6:0] seg;
        bit to;
        doReset(1);
        applyStimulus(9, 1'b0);
        waitDigit(0, seg, to);
        nCompared++;
        if (to || seg !== 7'h6F) begin nMismatched++; $display("[TB] FAIL midop_preA: got %h (timeout %0d) expected 6F", seg, to); end
        doReset(1);
        nCompared++;
        if (state_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL midop_state: got %b expected 00", state_out); end
        for (int d = 0; d < ND; d++) begin
            waitDigit(d, seg, to);
            nCompared++;
            if (to || seg !== 7'h3F) begin nMismatched++; $display("[TB] FAIL midop_digit%0d: got %h (timeout %0d) expected 3F", d, seg, to); end
        end
        applyStimulus(1, 1'b0);
        applyStimulus(1, 1'b0);
        nCompared++;
        if (f_out !== 4'h2) begin nMismatched++; $display("[TB] FAIL midop_f: got %h expected 2", f_out); end
        nCompared++;
        if (L_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL midop_L: got %b expected 0", L_out); end
    endtask

    task automatic test_random;
        logic [6:0] seg;
        bit to;
        int val;
        int glitchLen;
        int prevState;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                doReset(1 + $urandom_range(0, 2));
                nCompared++;
                if (state_out !== 2'b00) begin nMismatched++; $display("[TB] FAIL rnd_reset: got %b expected 00", state_out); end
            end
            if ($urandom_range(0, 3) == 0) begin
                glitchLen = $urandom_range(1, DC - 1);
                prevState = mState;
                @(negedge clk);
                btn_enter = 1'b1;
                repeat (glitchLen) @(posedge clk);
                @(negedge clk);
                btn_enter = 1'b0;
                repeat (12) @(posedge clk);
                @(negedge clk);
                nCompared++;
                if (state_out !== 2'(prevState)) begin nMismatched++; $display("[TB] FAIL rnd_glitch: got %b expected %0d", state_out, prevState); end
            end
            val = $urandom_range(0, 15);
            applyStimulus(val, 1'($urandom_range(0, 1)));
            nCompared++;
            if (state_out !== 2'(mState)) begin nMismatched++; $display("[TB] FAIL rnd_state: got %b expected %0d", state_out, mState); end
            nCompared++;
            if (f_out !== W'(mSum & 15)) begin nMismatched++; $display("[TB] FAIL rnd_f: got %h expected %h", f_out, mSum & 15); end
            nCompared++;
            if (L_out !== 1'(mSum >> W)) begin nMismatched++; $display("[TB] FAIL rnd_L: got %b expected %0d", L_out, mSum >> W); end
            for (int d = 0; d < ND; d++) begin
                waitDigit(d, seg, to);
                nCompared++;
                if (to || seg !== expSeg(d)) begin nMismatched++; $display("[TB] FAIL rnd_digit%0d: got %h (timeout %0d) expected %h", d, seg, to, expSeg(d)); end
            end
        end
    endtask

    initial begin
        $display("[TB] starting button_adder_display bench");
        test_reset();
        test_basic_add();
        test_carry();
        test_glitch_latency();
        test_capture_timing();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/button_adder_display.md
Name: button_adder_display

Overview:
- Parametrised successor of the button-read adder in system_top.
- Debounces a pushbutton and captures two W-bit operands from switches.
- Registers their sum and carry, and drives a time-multiplexed N_DIG-digit hex 7-segment display.
- Sits between board I/O (switches, enter button) and the display/LED pins.

Parameters:
W, 4, operand/sum width in bits (1..16)
DEBOUNCE_CYC, 4, consecutive stable cycles needed to accept a button level change (>=2)
N_DIG, 2, number of multiplexed hex digits (1..8)
REFRESH_CYC, 8, clock cycles each digit stays enabled (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
btn_input  in  W  operand switches, sampled at the capture edge
btn_enter  in  1  raw asynchronous enter pushbutton, active-high
f_out  out  W  registered sum, modulo 2^W
L_out  out  1  registered carry-out of the last addition
seg7_out  out  7  active-high segments, bit0=a .. bit6=g
an_out  out  N_DIG  one-hot active-high digit enable
state_out  out  2  FSM state: 00 WAIT_A, 01 WAIT_B, 10 SHOW

Behaviour:
- Reset (rst_n low at a clock edge) clears every register:
  - State is WAIT_A; operand reg a, f_out and L_out are 0.
  - Sync/debounce registers and the debounce counter are 0.
  - Refresh counter and digit index are 0, so an_out=1 and seg7_out=7'h3F.
- Reset mid-operation abandons any captured operand. There is no partial recovery.
- Input conditioning:
  - btn_enter passes through a 2-FF synchroniser to give s2.
  - Debounced level db and counter cnt: if s2==db, cnt<=0. Otherwise cnt increments, and when cnt==DEBOUNCE_CYC-1, db<=s2 and cnt<=0.
  - enter_pulse is a 1-cycle registered pulse on a db 0->1 transition.
  - Latency: if edge k is the first edge sampling btn_enter high, and the button stays high, the FSM acts at edge k+DEBOUNCE_CYC+2.
  - A high glitch shorter than DEBOUNCE_CYC cycles after synchronisation produces no pulse.
  - Holding the button produces exactly one pulse. Release must also be debounced before the next press is accepted.
- FSM, advancing only on enter_pulse:
  - WAIT_A: a<=btn_input; go to WAIT_B.
  - WAIT_B: {L_out,f_out}<=a+btn_input as (W+1)-bit unsigned; go to SHOW.
  - SHOW: a<=btn_input; go to WAIT_B (start a new sum). f_out/L_out hold until the next WAIT_B capture.
- btn_input is sampled only on the capture edge. Its value at press time is irrelevant.
- Display value dv:
  - WAIT_A: 0.
  - WAIT_B: a.
  - SHOW: {L_out,f_out}.
  - dv is zero-extended or truncated to 4*N_DIG bits; digit i shows nibble i (digit 0 = least significant).
- Multiplexing:
  - Refresh counter counts 0..REFRESH_CYC-1. On wrap, the digit index increments, wrapping from N_DIG-1 to 0.
  - an_out = 1<<index. N_DIG=1 keeps an_out=1 permanently.
  - seg7_out is the combinational decode of the current nibble from registered index and dv. No blanking.
- Hex decode (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- state_out and every output update only on clock edges. seg7_out may change only after a register change.

Test Plan:
Default parameters apply (W=4, DEBOUNCE_CYC=4, N_DIG=2, REFRESH_CYC=8); each press is held 10 cycles and followed by a 10-cycle release.
1. rst_n low 3 cycles, then high -> state_out=00, f_out=0000, L_out=0, an_out=01, seg7_out=3F; an_out becomes 10 after 8 cycles.
2. btn_input=3, press -> state_out=01, digit0 shows 4F; btn_input=5, press -> f_out=1000, L_out=0, state_out=10, digit0=7F, digit1=3F.
3. Operands 9 then A -> f_out=0011, L_out=1, digit0=4F, digit1=06; next press with btn_input=2 -> state_out=01, f_out still 0011.
4. btn_enter high 3 cycles -> no state change. High exactly from edge k -> state changes at edge k+6, not before. Held 50 cycles -> exactly one transition.
5. btn_input changed from 6 to 7 during debounce of a WAIT_A press -> a captures 7, the value present at the capture edge.
6. rst_n low one cycle while in WAIT_B with a=9 -> state_out=00, display 00, a=0; a subsequent 1+1 sequence gives f_out=0010, L_out=0.
